// File: rtl/ldst_mem_responder.sv
// LSU memory responder: arbitrates load/store requests onto a single-port SRAM and returns tagged responses.
// Optional macro LEN5_MEM_RESP_RR_ARB_EN selects round-robin arbitration; the default is store-over-load priority.
`ifndef BUFF_IDX_LEN
`define BUFF_IDX_LEN 4
`endif

module ldst_mem_responder #(
    parameter int unsigned     XLEN       = 32,
    parameter logic [XLEN-1:0] MEM_BASE   = XLEN'(32'h0001_0000),
    parameter int unsigned     MEM_WORDS  = 1024,
    parameter int unsigned     RESP_DEPTH = 2,
    parameter int unsigned     TAG_W      = `BUFF_IDX_LEN
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         ld_req_valid_i,
    output logic                         ld_req_ready_o,
    input  logic                         ld_req_we_i,
    input  logic [XLEN-1:0]              ld_req_addr_i,
    input  logic [3:0]                   ld_req_be_i,
    input  logic [TAG_W-1:0]             ld_req_tag_i,
    input  logic                         st_req_valid_i,
    output logic                         st_req_ready_o,
    input  logic                         st_req_we_i,
    input  logic [XLEN-1:0]              st_req_addr_i,
    input  logic [3:0]                   st_req_be_i,
    input  logic [31:0]                  st_req_wdata_i,
    input  logic [TAG_W-1:0]             st_req_tag_i,
    output logic                         ld_rsp_valid_o,
    input  logic                         ld_rsp_ready_i,
    output logic [31:0]                  ld_rsp_rdata_o,
    output logic [TAG_W-1:0]             ld_rsp_tag_o,
    output logic                         ld_rsp_except_raised_o,
    output logic [4:0]                   ld_rsp_except_code_o,
    output logic                         st_rsp_valid_o,
    input  logic                         st_rsp_ready_i,
    output logic [31:0]                  st_rsp_rdata_o,
    output logic [TAG_W-1:0]             st_rsp_tag_o,
    output logic                         st_rsp_except_raised_o,
    output logic [4:0]                   st_rsp_except_code_o,
    output logic                         sram_req_o,
    output logic                         sram_we_o,
    output logic [$clog2(MEM_WORDS)-1:0] sram_addr_o,
    output logic [3:0]                   sram_be_o,
    output logic [31:0]                  sram_wdata_o,
    input  logic [31:0]                  sram_rdata_i
);

    localparam int unsigned AW = $clog2(MEM_WORDS);
    localparam int unsigned PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int unsigned CW = $clog2(RESP_DEPTH + 1);
    localparam int unsigned EW = TAG_W + 1 + 5 + 32;
    localparam logic [CW:0]   DEPTH_C = (CW + 1)'(RESP_DEPTH);
    localparam logic [XLEN:0] MEM_LO  = {1'b0, MEM_BASE};
    localparam logic [XLEN:0] MEM_END = MEM_LO + (XLEN + 1)'(4 * MEM_WORDS);

    localparam logic [4:0] E_LD_ADDR_MISALIGNED = 5'd4;
    localparam logic [4:0] E_LD_ACCESS_FAULT    = 5'd5;
    localparam logic [4:0] E_ST_ADDR_MISALIGNED = 5'd6;
    localparam logic [4:0] E_ST_ACCESS_FAULT    = 5'd7;

    function automatic logic be_legal(input logic [3:0] be);
        case (be)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: be_legal = 1'b1;
            default:                   be_legal = 1'b0;
        endcase
    endfunction

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        ptr_next = (p == PW'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Channel index 0 = load, 1 = store
    logic             req_valid [2];
    logic             req_we    [2];
    logic [XLEN-1:0]  req_addr  [2];
    logic [3:0]       req_be    [2];
    logic [31:0]      req_wdata [2];
    logic [TAG_W-1:0] req_tag   [2];
    logic             req_exc   [2];
    logic [4:0]       req_code  [2];
    logic [CW-1:0]    occ       [2];
    logic [CW:0]      cnt       [2];
    logic             elig      [2];
    logic             rsp_ready [2];
    logic             rsp_valid [2];
    logic [EW-1:0]    rsp_entry [2];

    assign req_valid[0] = ld_req_valid_i;
    assign req_valid[1] = st_req_valid_i;
    assign req_we[0]    = ld_req_we_i;
    assign req_we[1]    = st_req_we_i;
    assign req_addr[0]  = ld_req_addr_i;
    assign req_addr[1]  = st_req_addr_i;
    assign req_be[0]    = ld_req_be_i;
    assign req_be[1]    = st_req_be_i;
    assign req_wdata[0] = '0;
    assign req_wdata[1] = st_req_wdata_i;
    assign req_tag[0]   = ld_req_tag_i;
    assign req_tag[1]   = st_req_tag_i;
    assign rsp_ready[0] = ld_rsp_ready_i;
    assign rsp_ready[1] = st_rsp_ready_i;

    logic             inf_v;
    logic             inf_ch;
    logic [TAG_W-1:0] inf_tag;
    logic             inf_exc;
    logic [4:0]       inf_code;
    logic             inf_rd;
    logic [EW-1:0]    push_entry;

    assign push_entry = {inf_tag, inf_exc, inf_code, (inf_rd ? sram_rdata_i : 32'h0)};

    for (genvar c = 0; c < 2; c++) begin : g_ch
        localparam logic CH = (c == 1);
        logic mis, oob, push, pop, bypass, store, deq;
        logic [PW-1:0] rd_ptr, wr_ptr;
        logic [EW-1:0] mem [RESP_DEPTH];

        assign mis = !be_legal(req_be[c]);
        assign oob = ({1'b0, req_addr[c]} < MEM_LO) || ({1'b0, req_addr[c]} >= MEM_END);
        assign req_exc[c] = mis || oob;

        always_comb begin
            req_code[c] = '0;
            if (mis)      req_code[c] = req_we[c] ? E_ST_ADDR_MISALIGNED : E_LD_ADDR_MISALIGNED;
            else if (oob) req_code[c] = req_we[c] ? E_ST_ACCESS_FAULT : E_LD_ACCESS_FAULT;
        end

        assign cnt[c]  = {1'b0, occ[c]} + (CW + 1)'(inf_v && (inf_ch == CH));
        assign elig[c] = req_valid[c] && (cnt[c] < DEPTH_C);

        // Fall-through: an in-flight entry arriving at an empty FIFO is presented directly
        // and, if consumed the same cycle, never written into storage.
        assign push   = inf_v && (inf_ch == CH);
        assign rsp_valid[c] = (occ[c] != '0) || push;
        assign pop    = rsp_valid[c] && rsp_ready[c];
        assign bypass = push && (occ[c] == '0) && pop;
        assign store  = push && !bypass;
        assign deq    = pop && (occ[c] != '0);
        assign rsp_entry[c] = (occ[c] != '0) ? mem[rd_ptr] : (push ? push_entry : '0);

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                occ[c] <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                occ[c] <= occ[c] + CW'(store) - CW'(deq);
                if (store) wr_ptr <= ptr_next(wr_ptr);
                if (deq)   rd_ptr <= ptr_next(rd_ptr);
            end
        end

        always_ff @(posedge clk_i) begin
            if (store) mem[wr_ptr] <= push_entry;
        end
    end

    logic grant_ld, grant_st, accept, sel;

`ifdef LEN5_MEM_RESP_RR_ARB_EN
    logic rr_ptr;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                        rr_ptr <= 1'b0;
        else if (accept && sel == rr_ptr) rr_ptr <= !rr_ptr;
    end
`endif

    always_comb begin
`ifdef LEN5_MEM_RESP_RR_ARB_EN
        grant_st = elig[1] && (!elig[0] || rr_ptr);
`else
        grant_st = elig[1];
`endif
        grant_ld = elig[0] && !grant_st;
        grant_st = grant_st && !rst_i;
        grant_ld = grant_ld && !rst_i;
    end

    assign accept         = grant_ld || grant_st;
    assign sel            = grant_st;
    assign ld_req_ready_o = grant_ld;
    assign st_req_ready_o = grant_st;

    always_comb begin
        sram_req_o   = 1'b0;
        sram_we_o    = 1'b0;
        sram_addr_o  = '0;
        sram_be_o    = '0;
        sram_wdata_o = '0;
        if (accept && !req_exc[sel]) begin
            sram_req_o   = 1'b1;
            sram_we_o    = req_we[sel];
            sram_addr_o  = AW'((req_addr[sel] - MEM_BASE) >> 2);
            sram_be_o    = req_be[sel];
            sram_wdata_o = req_wdata[sel];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            inf_v    <= 1'b0;
            inf_ch   <= 1'b0;
            inf_tag  <= '0;
            inf_exc  <= 1'b0;
            inf_code <= '0;
            inf_rd   <= 1'b0;
        end else begin
            inf_v <= accept;
            if (accept) begin
                inf_ch   <= sel;
                inf_tag  <= req_tag[sel];
                inf_exc  <= req_exc[sel];
                inf_code <= req_code[sel];
                inf_rd   <= !req_we[sel] && !req_exc[sel];
            end
        end
    end

    assign ld_rsp_valid_o         = rsp_valid[0];
    assign ld_rsp_tag_o           = rsp_entry[0][EW-1 -: TAG_W];
    assign ld_rsp_except_raised_o = rsp_entry[0][37];
    assign ld_rsp_except_code_o   = rsp_entry[0][36:32];
    assign ld_rsp_rdata_o         = rsp_entry[0][31:0];
    assign st_rsp_valid_o         = rsp_valid[1];
    assign st_rsp_tag_o           = rsp_entry[1][EW-1 -: TAG_W];
    assign st_rsp_except_raised_o = rsp_entry[1][37];
    assign st_rsp_except_code_o   = rsp_entry[1][36:32];
    assign st_rsp_rdata_o         = rsp_entry[1][31:0];

endmodule

// File: tb/tb_ldst_mem_responder.sv
// Directed bench for ldst_mem_responder with a behavioural SRAM; expectations follow LEN5_MEM_RESP_RR_ARB_EN.
module tb_ldst_mem_responder;

    localparam logic [31:0] BASE = 32'h0001_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ld_req_valid = 0, ld_req_we = 0, st_req_valid = 0, st_req_we = 0;
    logic [31:0] ld_req_addr = '0, st_req_addr = '0, st_req_wdata = '0;
    logic [3:0]  ld_req_be = '0, st_req_be = '0, ld_req_tag = '0, st_req_tag = '0;
    logic        ld_rsp_ready = 1'b1, st_rsp_ready = 1'b1;
    logic        ld_req_ready, st_req_ready, ld_rsp_valid, st_rsp_valid;
    logic [31:0] ld_rsp_rdata, st_rsp_rdata;
    logic [3:0]  ld_rsp_tag, st_rsp_tag;
    logic        ld_rsp_exc, st_rsp_exc;
    logic [4:0]  ld_rsp_code, st_rsp_code;
    logic        sram_req, sram_we;
    logic [9:0]  sram_addr;
    logic [3:0]  sram_be;
    logic [31:0] sram_wdata, sram_rdata;
    logic [31:0] sram [1024];

    int errors = 0;
    int checks = 0;

    ldst_mem_responder #(
        .XLEN(32), .MEM_BASE(BASE), .MEM_WORDS(1024), .RESP_DEPTH(2), .TAG_W(4)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .ld_req_valid_i(ld_req_valid), .ld_req_ready_o(ld_req_ready), .ld_req_we_i(ld_req_we),
        .ld_req_addr_i(ld_req_addr), .ld_req_be_i(ld_req_be), .ld_req_tag_i(ld_req_tag),
        .st_req_valid_i(st_req_valid), .st_req_ready_o(st_req_ready), .st_req_we_i(st_req_we),
        .st_req_addr_i(st_req_addr), .st_req_be_i(st_req_be), .st_req_wdata_i(st_req_wdata),
        .st_req_tag_i(st_req_tag),
        .ld_rsp_valid_o(ld_rsp_valid), .ld_rsp_ready_i(ld_rsp_ready), .ld_rsp_rdata_o(ld_rsp_rdata),
        .ld_rsp_tag_o(ld_rsp_tag), .ld_rsp_except_raised_o(ld_rsp_exc), .ld_rsp_except_code_o(ld_rsp_code),
        .st_rsp_valid_o(st_rsp_valid), .st_rsp_ready_i(st_rsp_ready), .st_rsp_rdata_o(st_rsp_rdata),
        .st_rsp_tag_o(st_rsp_tag), .st_rsp_except_raised_o(st_rsp_exc), .st_rsp_except_code_o(st_rsp_code),
        .sram_req_o(sram_req), .sram_we_o(sram_we), .sram_addr_o(sram_addr), .sram_be_o(sram_be),
        .sram_wdata_o(sram_wdata), .sram_rdata_i(sram_rdata)
    );

    always #5 clk = ~clk;

    // Single-port synchronous SRAM; a few words are preloaded while reset is held.
    always @(posedge clk) begin
        if (rst) begin
            sram[1] <= 32'hAAAA_5555;
            sram[2] <= 32'hDEAD_BEEF;
        end else if (sram_req) begin
            if (sram_we) begin
                for (int b = 0; b < 4; b++)
                    if (sram_be[b]) sram[sram_addr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
            end else begin
                sram_rdata <= sram[sram_addr];
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_ld(input logic v, input logic [31:0] a, input logic [3:0] be, input logic [3:0] t);
        ld_req_valid = v; ld_req_we = 1'b0; ld_req_addr = a; ld_req_be = be; ld_req_tag = t;
    endtask

    task automatic drive_st(input logic v, input logic [31:0] a, input logic [3:0] be,
                            input logic [31:0] d, input logic [3:0] t);
        st_req_valid = v; st_req_we = 1'b1; st_req_addr = a; st_req_be = be; st_req_wdata = d; st_req_tag = t;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] exp_ld, exp_st;
`ifdef LEN5_MEM_RESP_RR_ARB_EN
        exp_ld = 4'b0101; exp_st = 4'b1010;
`else
        exp_ld = 4'b0000; exp_st = 4'b1111;
`endif
        // Reset state with a pending request
        drive_ld(1, BASE, 4'hF, 0);
        @(negedge clk); #1;
        chk("rst_ld_ready", ld_req_ready, 0);
        chk("rst_sram_req", sram_req, 0);
        chk("rst_ld_rsp_valid", ld_rsp_valid, 0);
        drive_ld(0, 0, 0, 0);
        @(negedge clk); rst = 0;

        // Aligned load
        @(negedge clk); drive_ld(1, BASE + 8, 4'hF, 3); #1;
        chk("ld_ready", ld_req_ready, 1);
        chk("ld_st_ready", st_req_ready, 0);
        chk("ld_sram_req", sram_req, 1);
        chk("ld_sram_addr", sram_addr, 2);
        chk("ld_sram_we", sram_we, 0);
        @(negedge clk); drive_ld(0, 0, 0, 0); #1;
        chk("ld_rsp_valid", ld_rsp_valid, 1);
        chk("ld_rsp_rdata", ld_rsp_rdata, 32'hDEAD_BEEF);
        chk("ld_rsp_tag", ld_rsp_tag, 3);
        chk("ld_rsp_exc", ld_rsp_exc, 0);

        // Halfword store then reload
        @(negedge clk); drive_st(1, BASE + 4, 4'b1100, 32'h1234_5678, 5); #1;
        chk("st_ready", st_req_ready, 1);
        chk("st_sram_we", sram_we, 1);
        chk("st_sram_be", sram_be, 4'b1100);
        chk("st_sram_addr", sram_addr, 1);
        chk("st_sram_wdata", sram_wdata, 32'h1234_5678);
        @(negedge clk); drive_st(0, 0, 0, 0, 0); drive_ld(1, BASE + 4, 4'hF, 6); #1;
        chk("st_rsp_valid", st_rsp_valid, 1);
        chk("st_rsp_rdata", st_rsp_rdata, 0);
        chk("st_rsp_tag", st_rsp_tag, 5);
        chk("reload_ready", ld_req_ready, 1);
        @(negedge clk); drive_ld(0, 0, 0, 0); #1;
        chk("reload_rdata", ld_rsp_rdata, 32'h1234_5555);
        chk("reload_tag", ld_rsp_tag, 6);

        // Exceptions and range boundaries
        @(negedge clk); drive_ld(1, BASE, 4'b0110, 7); #1;
        chk("mis_ready", ld_req_ready, 1);
        chk("mis_sram_req", sram_req, 0);
        @(negedge clk); drive_ld(0, 0, 0, 0); drive_st(1, BASE - 4, 4'hF, 32'h5, 8); #1;
        chk("mis_exc", ld_rsp_exc, 1);
        chk("mis_code", ld_rsp_code, 4);
        chk("mis_rdata", ld_rsp_rdata, 0);
        chk("mis_tag", ld_rsp_tag, 7);
        chk("staf_sram_req", sram_req, 0);
        @(negedge clk); drive_st(0, 0, 0, 0, 0); drive_ld(1, BASE + 4092, 4'hF, 9); #1;
        chk("staf_exc", st_rsp_exc, 1);
        chk("staf_code", st_rsp_code, 7);
        chk("staf_tag", st_rsp_tag, 8);
        chk("top_sram_req", sram_req, 1);
        chk("top_sram_addr", sram_addr, 1023);
        @(negedge clk); drive_ld(1, BASE + 4096, 4'hF, 10); #1;
        chk("top_exc", ld_rsp_exc, 0);
        chk("top_tag", ld_rsp_tag, 9);
        chk("end_sram_req", sram_req, 0);
        @(negedge clk); drive_ld(1, BASE - 4, 4'b0101, 11); #1;
        chk("end_code", ld_rsp_code, 5);
        chk("end_tag", ld_rsp_tag, 10);
        @(negedge clk); drive_ld(0, 0, 0, 0); #1;
        chk("prio_code", ld_rsp_code, 4);
        chk("prio_tag", ld_rsp_tag, 11);

        // Response FIFO full, backpressure
        @(negedge clk); ld_rsp_ready = 0; drive_ld(1, BASE, 4'hF, 1); #1;
        chk("full_acc1", ld_req_ready, 1);
        @(negedge clk); drive_ld(1, BASE, 4'hF, 2); #1;
        chk("full_acc2", ld_req_ready, 1);
        @(negedge clk); drive_ld(1, BASE, 4'hF, 3); #1;
        chk("full_blk1", ld_req_ready, 0);
        @(negedge clk); #1;
        chk("full_blk2", ld_req_ready, 0);
        chk("full_head1", ld_rsp_tag, 1);
        ld_rsp_ready = 1; #1;
        chk("full_popsame", ld_req_ready, 0);
        @(negedge clk); ld_rsp_ready = 0; #1;
        chk("full_acc3", ld_req_ready, 1);
        chk("full_head2", ld_rsp_tag, 2);
        @(negedge clk); drive_ld(0, 0, 0, 0); #1;
        chk("full_hold", ld_rsp_tag, 2);
        ld_rsp_ready = 1;
        @(negedge clk); #1;
        chk("full_head3v", ld_rsp_valid, 1);
        chk("full_head3", ld_rsp_tag, 3);
        @(negedge clk); #1;
        chk("full_empty", ld_rsp_valid, 0);

        // Arbitration with both channels valid
        @(negedge clk); rst = 1;
        @(negedge clk); rst = 0;
        @(negedge clk); drive_ld(1, BASE + 8, 4'hF, 9); drive_st(1, BASE + 12, 4'hF, 0, 10);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("arb_ld", ld_req_ready, exp_ld[i]);
            chk("arb_st", st_req_ready, exp_st[i]);
            @(negedge clk);
        end
        drive_st(0, 0, 0, 0, 0); #1;
        chk("arb_ld_after", ld_req_ready, 1);
        @(negedge clk); drive_ld(0, 0, 0, 0);
        @(negedge clk);

        // Reset with an in-flight request and occupied FIFOs
        @(negedge clk); ld_rsp_ready = 0; st_rsp_ready = 0; drive_ld(1, BASE, 4'hF, 1);
        @(negedge clk); drive_ld(0, 0, 0, 0); drive_st(1, BASE + 16, 4'hF, 32'h77, 2);
        @(negedge clk); drive_st(0, 0, 0, 0, 0); drive_ld(1, BASE + 8, 4'hF, 3);
        @(negedge clk); drive_ld(0, 0, 0, 0); drive_st(1, BASE + 16, 4'hF, 32'h77, 4); #1;
        chk("pre_ld_valid", ld_rsp_valid, 1);
        chk("pre_st_valid", st_rsp_valid, 1);
        rst = 1; #1;
        chk("rr_ld_valid", ld_rsp_valid, 0);
        chk("rr_st_valid", st_rsp_valid, 0);
        chk("rr_ld_tag", ld_rsp_tag, 0);
        chk("rr_st_tag", st_rsp_tag, 0);
        chk("rr_ld_rdata", ld_rsp_rdata, 0);
        chk("rr_ld_exc", ld_rsp_exc, 0);
        chk("rr_st_ready", st_req_ready, 0);
        chk("rr_sram_req", sram_req, 0);
        chk("rr_sram_wdata", sram_wdata, 0);
        @(negedge clk); drive_st(0, 0, 0, 0, 0); rst = 0; ld_rsp_ready = 1; st_rsp_ready = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("post_ld_valid", ld_rsp_valid, 0);
            chk("post_st_valid", st_rsp_valid, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
